// File: rtl/sobel_ctrl_pkg.sv
// rtl/sobel_ctrl_pkg.sv - shared state encoding and default geometry for the sobel frame sequencer
package sobel_ctrl_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sobel_linebuf.sv
// rtl/sobel_linebuf.sv - one-line pixel store, one access per cycle, read returns old data at the written address
module sobel_linebuf #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_ctrl.sv
// rtl/sobel_ctrl.sv - raster-in / edge-bit-out frame sequencer wrapping an external 3x3 sobel stage
module sobel_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic [PIX_W-1:0] pix_0,
    output logic [PIX_W-1:0] pix_1,
    output logic [PIX_W-1:0] pix_2,
    output logic [PIX_W-1:0] pix_3,
    output logic [PIX_W-1:0] pix_5,
    output logic [PIX_W-1:0] pix_6,
    output logic [PIX_W-1:0] pix_7,
    output logic [PIX_W-1:0] pix_8,
    input  logic             edge_in,
    output logic             out_valid,
    output logic             out_edge,
    output logic             out_sof,
    output logic             out_eol
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW:0]   F_LAST = (XW + 1)'(IMG_W);

    state_t state, state_nx;

    logic [XW-1:0]    ix, ox;
    logic [YW-1:0]    iy, oy;
    logic [XW:0]      fcnt;
    logic             adv, adv_run, produce, last_in;
    logic [PIX_W-1:0] new_pix, lb0_rd, lb1_rd;
    logic [PIX_W-1:0] win [9];
    logic             pend, pend_border, pend_sof, pend_eol;

    assign in_ready = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    assign adv_run = in_ready & in_valid;
    assign adv     = adv_run | (state == ST_FLUSH);
    assign new_pix = (state == ST_RUN) ? in_pix : '0;
    assign last_in = adv_run && (ix == X_LAST) && (iy == Y_LAST);

    // The first IMG_W+1 inputs only prime the window; every flush advance yields a result.
    assign produce = adv && ((state == ST_FLUSH) || (iy >= YW'(2)) ||
                             ((iy == YW'(1)) && (ix != '0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (last_in) state_nx = ST_FLUSH;
            ST_FLUSH: if (fcnt == F_LAST) state_nx = ST_DRAIN;
            ST_DRAIN: if (fcnt == (XW + 1)'(1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ix   <= '0;
            iy   <= '0;
            ox   <= '0;
            oy   <= '0;
            fcnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            ix   <= '0;
            iy   <= '0;
            ox   <= '0;
            oy   <= '0;
            fcnt <= '0;
        end else begin
            if (adv) begin
                ix <= (ix == X_LAST) ? '0 : ix + 1'b1;
                if ((state == ST_RUN) && (ix == X_LAST)) begin
                    iy <= (iy == Y_LAST) ? '0 : iy + 1'b1;
                end
            end
            if (produce) begin
                ox <= (ox == X_LAST) ? '0 : ox + 1'b1;
                if (ox == X_LAST) begin
                    oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
                end
            end
            // fcnt counts flush advances, then is reused to time the two drain cycles.
            if (state == ST_FLUSH) begin
                fcnt <= (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
            end else if (state == ST_DRAIN) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    sobel_linebuf #(.DEPTH(IMG_W), .AW(XW), .DW(PIX_W)) lb0 (
        .clk   (clk),
        .en    (adv),
        .addr  (ix),
        .wdata (new_pix),
        .rdata (lb0_rd)
    );

    sobel_linebuf #(.DEPTH(IMG_W), .AW(XW), .DW(PIX_W)) lb1 (
        .clk   (clk),
        .en    (adv),
        .addr  (ix),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (adv) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= new_pix;
        end
    end

    assign pix_0 = win[0];
    assign pix_1 = win[1];
    assign pix_2 = win[2];
    assign pix_3 = win[3];
    assign pix_5 = win[5];
    assign pix_6 = win[6];
    assign pix_7 = win[7];
    assign pix_8 = win[8];

    // Position flags are captured with the window update; edge_in is sampled one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend        <= 1'b0;
            pend_border <= 1'b0;
            pend_sof    <= 1'b0;
            pend_eol    <= 1'b0;
            out_valid   <= 1'b0;
            out_edge    <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
        end else begin
            pend        <= produce;
            pend_border <= (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
            pend_sof    <= (ox == '0) && (oy == '0);
            pend_eol    <= (ox == X_LAST);
            out_valid   <= pend;
            out_edge    <= pend & edge_in & ~pend_border;
            out_sof     <= pend & pend_sof;
            out_eol     <= pend & pend_eol;
        end
    end

endmodule

// File: tb/tb_sobel_ctrl.sv
// tb/tb_sobel_ctrl.sv - randomized frame bench for sobel_ctrl against an image-level edge model
module tb_sobel_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int N   = W * H;
    localparam int THR = 128;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] in_pix;
    logic       busy, done, in_ready, edge_in;
    logic [7:0] pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8;
    logic       out_valid, out_edge, out_sof, out_eol;

    logic [7:0] img [N];
    logic       exp_edge [N];

    int tests = 0, fails = 0;
    int cyc = 0, out_cnt = 0, done_cnt = 0, last_v_cyc = -100;

    always #5 clk = ~clk;

    function automatic logic sobel_fn(input int p0, p1, p2, p3, p5, p6, p7, p8);
        int gx, gy;
        gx = (p2 + 2 * p5 + p8) - (p0 + 2 * p3 + p6);
        gy = (p6 + 2 * p7 + p8) - (p0 + 2 * p1 + p2);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) >= THR;
    endfunction

    assign edge_in = sobel_fn(int'(pix_0), int'(pix_1), int'(pix_2), int'(pix_3),
                              int'(pix_5), int'(pix_6), int'(pix_7), int'(pix_8));

    sobel_ctrl #(.IMG_W(W), .IMG_H(H), .XW(3), .YW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .pix_0     (pix_0),
        .pix_1     (pix_1),
        .pix_2     (pix_2),
        .pix_3     (pix_3),
        .pix_5     (pix_5),
        .pix_6     (pix_6),
        .pix_7     (pix_7),
        .pix_8     (pix_8),
        .edge_in   (edge_in),
        .out_valid (out_valid),
        .out_edge  (out_edge),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            if (out_cnt < N) begin
                check("edge", 32'(out_edge), 32'(exp_edge[out_cnt]));
                check("sof", 32'(out_sof), 32'(out_cnt == 0));
                check("eol", 32'(out_eol), 32'((out_cnt % W) == W - 1));
            end else begin
                check("extra_valid", 32'(out_valid), 32'd0);
            end
            out_cnt++;
            last_v_cyc = cyc;
        end else begin
            check("idle_marks", {29'd0, out_edge, out_sof, out_eol}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            check("done_gap", cyc - last_v_cyc, 32'd1);
        end
    end

    task automatic fill_image(input int kind);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       img[y * W + x] = 8'd100;
                    1:       img[y * W + x] = (x >= 4) ? 8'd255 : 8'd0;
                    2:       img[y * W + x] = (y >= 3) ? 8'd200 : 8'd0;
                    3:       img[y * W + x] = 8'($urandom_range(255));
                    default: img[y * W + x] = $urandom_range(1) ? 8'd255 : 8'd0;
                endcase
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int i;
                i = y * W + x;
                if (x == 0 || x == W - 1 || y == 0 || y == H - 1) begin
                    exp_edge[i] = 1'b0;
                end else begin
                    exp_edge[i] = sobel_fn(img[i - W - 1], img[i - W], img[i - W + 1],
                                           img[i - 1], img[i + 1],
                                           img[i + W - 1], img[i + W], img[i + W + 1]);
                end
            end
        end
        out_cnt    = 0;
        done_cnt   = 0;
        last_v_cyc = -100;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic feed(input int limit, input int duty, input bit pulse_mid);
        int  idx = 0;
        int  budget = 3000;
        bit  acc;
        while (idx < limit && budget > 0) begin
            in_valid = ($urandom_range(99) < duty);
            in_pix   = img[idx];
            start    = pulse_mid && (idx == N / 2);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget--;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("feed_count", idx, limit);
    endtask

    task automatic run_frame(input int kind, input int duty, input bit pulse);
        fill_image(kind);
        pulse_start();
        feed(N, duty, pulse);
        if (pulse) begin
            check("busy_run_pulse", 32'(busy), 32'd1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_flush_pulse", 32'(busy), 32'd1);
        end
        for (int i = 0; i < 200 && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt, 32'd1);
        check("out_count", out_cnt, N);
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pix   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pix", {8'd0, pix_0, pix_5, pix_8}, 32'd0);
        rst = 1'b1;

        run_frame(0, 100, 1'b0);
        run_frame(1, 100, 1'b0);
        run_frame(2, 100, 1'b0);
        run_frame(1, 40, 1'b0);
        run_frame(2, 40, 1'b1);

        fill_image(1);
        pulse_start();
        feed(20, 100, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_outs", {28'd0, out_valid, out_edge, out_sof, out_eol}, 32'd0);
        check("mid_rst_pix", {8'd0, pix_0, pix_5, pix_8}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);
        run_frame(1, 100, 1'b0);

        for (int f = 0; f < 4; f++) begin
            run_frame(3 + (f % 2), 30 + $urandom_range(70), 1'(f == 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sobel_ctrl.md
Name: sobel_ctrl

Overview:
Frame sequencer for the sobel edge datapath. Accepts a raster 8-bit greyscale pixel stream, keeps two line buffers and a 3x3 window, and drives the eight neighbour pixels to an external sobel instance. Returns the sobel edge bit as a raster 1-bit output stream with border masking and frame markers. Sits between the camera/pixel source and the edge-map sink.

Parameters:
IMG_W, 640, pixels per line (>=4)
IMG_H, 480, lines per frame (>=3)
XW, 10, column counter width (>= clog2(IMG_W))
YW, 9, row counter width (>= clog2(IMG_H))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begins a frame; ignored unless in IDLE
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse after the last output pixel
in_valid  in  1  input pixel valid
in_ready  out  1  high only in RUN
in_pix  in  8  input pixel, raster order
pix_0,pix_1,pix_2,pix_3,pix_5,pix_6,pix_7,pix_8  out  8 each  window to sobel; 0/1/2 = top row left..right, 3/5 = middle left/right, 6/7/8 = bottom row
edge_in  in  1  sobel out_data, combinational from pix_*
out_valid  out  1  output edge bit valid; no backpressure
out_edge  out  1  edge bit for (ox,oy)
out_sof  out  1  with out_valid, marks (0,0)
out_eol  out  1  with out_valid, marks ox==IMG_W-1

Behaviour:
- Reset (rst low, async): state IDLE; busy, done, in_ready, out_valid, out_edge, out_sof, out_eol, window regs, counters = 0. Line buffer memories are not reset.
- FSM: IDLE -start-> RUN; RUN -last input (IMG_W-1,IMG_H-1) accepted-> FLUSH; FLUSH -IMG_W+1 advances done-> DRAIN; DRAIN -final out_valid issued (2 cycles)-> DONE; DONE -> IDLE (done pulses 1 cycle in DONE).
- Advance: in RUN when in_valid & in_ready; in FLUSH every cycle, using pixel value 0. No advance otherwise; window, counters and buffers hold.
- Per advance at input column ix: new column = {lb1[ix], lb0[ix], in_pix} shifts into window right column (top, mid, bottom); window shifts left; lb1[ix] <= lb0[ix]; lb0[ix] <= in_pix. ix wraps IMG_W-1 -> 0 and increments iy.
- Output index = input linear index - (IMG_W+1). Advances with input index < IMG_W+1 produce no output. Output counters (ox,oy) advance only on producing advances, wrapping like ix/iy.
- Latency: producing advance at edge k updates window; sobel settles combinationally; at edge k+1 out_edge <= edge_in masked, out_valid = 1 for one cycle per producing advance. Total outputs per frame exactly IMG_W*IMG_H.
- Border mask: out_edge forced 0 when ox==0, ox==IMG_W-1, oy==0 or oy==IMG_H-1 (covers row wrap and uninitialised line-buffer contents).
- out_sof = (ox,oy)==(0,0); out_eol = ox==IMG_W-1; both qualified by out_valid, otherwise 0.
- in_valid gaps in RUN: pipeline stalls, no spurious out_valid; window and buffers hold.
- start while busy ignored. Reset mid-frame: immediate return to IDLE, partial frame discarded, no done.
- sobel arithmetic/threshold is external; this block neither inspects nor alters pixel values except zero fill in FLUSH.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, FLUSH, DRAIN, DONE), default IMG_W/IMG_H constants, pixel width 8.
- One sub-module: sobel_linebuf (single-port-per-cycle, IMG_W x 8, read-before-write at same address); instantiated twice (lb0, lb1). sobel itself instantiated alongside in the parent, not inside this block.

Test Plan:
- IMG_W=8, IMG_H=6, constant 100 frame, continuous in_valid -> 48 out_valid, all out_edge=0, out_sof on first, out_eol every 8th, done 1 cycle after last.
- Vertical step: columns 0..3 =0, 4..7 =255 -> out_edge=1 exactly at ox=3,4 for oy=1..4, 0 elsewhere incl. borders.
- Horizontal step rows 0..2 =0, 3..5 =200 -> out_edge=1 at oy=2,3, ox=1..6 only.
- Random in_valid duty 40% with step image -> output sequence identical to continuous case; out_valid never without a preceding advance.
- start pulsed during RUN and FLUSH -> ignored, busy stays high, output count still 48.
- rst low after 20 pixels -> all outputs 0 immediately, IDLE; new start + full frame -> correct 48 results.
